// File: rtl/mac_vlg_tx_buf.sv
// mac_vlg_tx_buf: store-and-forward single-frame TX buffer with zero padding.
// in_*: frame write side; out_*: frame read side to mac_vlg_tx; drop: overflow.
package mac_vlg_pkg;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
    logic [15:0] len;
  } mac_meta_t;
endpackage

module mac_vlg_tx_buf
  import mac_vlg_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 46,
  parameter int REQ_DLY = 4,
  parameter int IFG     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_dat,
  input  logic       in_val,
  input  logic       in_sof,
  input  logic       in_eof,
  input  mac_meta_t  in_meta,
  output logic       in_rdy,
  output logic [7:0] out_dat,
  output logic       out_val,
  output logic       out_sof,
  output logic       out_eof,
  output mac_meta_t  out_meta,
  output logic       out_rdy,
  input  logic       out_req,
  output logic       drop
);

  typedef enum logic [2:0] {
    IDLE, LOAD, READY, SEND, GAP
  } state_t;

  localparam logic [ADDR_W:0] FULL =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE =
    {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [16:0] D1   = 17'(REQ_DLY - 1);
  localparam logic [16:0] D2   = 17'(REQ_DLY - 2);
  localparam logic [15:0] MINL = 16'(MIN_LEN);
  localparam logic [15:0] IFGC = 16'(IFG);

  state_t state, nxt;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        ram_q;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] wa;
  logic              we;

  logic [ADDR_W:0] n, n_nxt;
  logic [47:0]     hdr_mac;
  logic [15:0]     hdr_typ;
  logic            hdr_ld;
  logic            drp;
  logic            acc;
  mac_meta_t       meta_new;
  logic [15:0]     n16;

  logic [16:0] t;
  logic [16:0] k_out;
  logic [16:0] len17;
  logic        win;
  logic        last;
  logic        pad;

  logic [15:0] gcnt;
  logic        gstart;

  logic        unused_len;
  assign unused_len = ^in_meta.len;

  assign acc   = in_val & in_rdy;
  assign len17 = 17'(out_meta.len);
  // t counts SEND cycles; read address leads output index by one
  assign k_out = t - D1;
  assign ra    = ADDR_W'(t - D2);
  assign win   = (state == SEND) && (t >= D1) &&
                 (k_out < len17);
  assign last  = k_out == len17 - 17'd1;
  assign pad   = k_out >= 17'(n);

  assign n16 = 16'(n_nxt);
  always_comb begin
    meta_new           = '0;
    meta_new.dst_mac   = hdr_ld ? in_meta.dst_mac
                                : hdr_mac;
    meta_new.ethertype = hdr_ld ? in_meta.ethertype
                                : hdr_typ;
    meta_new.len       = (n16 < MINL) ? MINL : n16;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    n_nxt  = n;
    we     = 1'b0;
    wa     = '0;
    hdr_ld = 1'b0;
    drp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc && in_sof) begin
          we     = 1'b1;
          hdr_ld = 1'b1;
          n_nxt  = ONE;
          nxt    = in_eof ? READY : LOAD;
        end
      end
      LOAD: begin
        if (acc) begin
          if (in_sof) begin
            we     = 1'b1;
            hdr_ld = 1'b1;
            n_nxt  = ONE;
            nxt    = in_eof ? READY : LOAD;
          end else if (n == FULL) begin
            drp   = 1'b1;
            n_nxt = '0;
            nxt   = IDLE;
          end else begin
            we    = 1'b1;
            wa    = n[ADDR_W-1:0];
            n_nxt = n + ONE;
            if (in_eof) nxt = READY;
          end
        end
      end
      READY: begin
        if (out_req) nxt = SEND;
      end
      SEND: begin
        if (win && last) nxt = GAP;
      end
      GAP: begin
        if ((gstart || !out_req) && gcnt == IFGC)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= in_dat;
    ram_q <= mem[ra];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n        <= '0;
      hdr_mac  <= '0;
      hdr_typ  <= '0;
      t        <= '0;
      gcnt     <= '0;
      gstart   <= 1'b0;
      in_rdy   <= 1'b0;
      out_rdy  <= 1'b0;
      out_val  <= 1'b0;
      out_sof  <= 1'b0;
      out_eof  <= 1'b0;
      out_dat  <= '0;
      out_meta <= '0;
      drop     <= 1'b0;
    end else begin
      n    <= n_nxt;
      drop <= drp;
      if (hdr_ld) begin
        hdr_mac <= in_meta.dst_mac;
        hdr_typ <= in_meta.ethertype;
      end
      t <= (state == SEND) ? t + 17'd1 : '0;
      // gap count starts once the request is released
      if (state == GAP) begin
        if (gstart || !out_req) begin
          gstart <= 1'b1;
          gcnt   <= gcnt + 16'd1;
        end
      end else begin
        gstart <= 1'b0;
        gcnt   <= '0;
      end
      in_rdy  <= (nxt == IDLE) || (nxt == LOAD);
      out_rdy <= nxt == READY;
      out_val <= win;
      out_sof <= win && (k_out == 17'd0);
      out_eof <= win && last;
      out_dat <= (win && !pad) ? ram_q : 8'h00;
      if (nxt == IDLE)
        out_meta <= '0;
      else if (nxt == READY && state != READY)
        out_meta <= meta_new;
    end
  end

endmodule

// File: tb/tb_mac_vlg_tx_buf.sv
// tb_mac_vlg_tx_buf: directed bench for mac_vlg_tx_buf.
// Expected bytes queue at load, popped by an output monitor.
module tb_mac_vlg_tx_buf;
  import mac_vlg_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int MIN_LEN = 46;
  localparam int REQ_DLY = 4;
  localparam int IFG     = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_dat = '0;
  logic       in_val = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_eof = 1'b0;
  mac_meta_t  in_meta = '0;
  logic       in_rdy;
  logic [7:0] out_dat;
  logic       out_val;
  logic       out_sof;
  logic       out_eof;
  mac_meta_t  out_meta;
  logic       out_rdy;
  logic       out_req = 1'b0;
  logic       drop;

  always #5 clk = ~clk;

  mac_vlg_tx_buf #(
    .ADDR_W (ADDR_W),
    .MIN_LEN(MIN_LEN),
    .REQ_DLY(REQ_DLY),
    .IFG    (IFG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (in_dat),
    .in_val  (in_val),
    .in_sof  (in_sof),
    .in_eof  (in_eof),
    .in_meta (in_meta),
    .in_rdy  (in_rdy),
    .out_dat (out_dat),
    .out_val (out_val),
    .out_sof (out_sof),
    .out_eof (out_eof),
    .out_meta(out_meta),
    .out_rdy (out_rdy),
    .out_req (out_req),
    .drop    (drop)
  );

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pl[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int r_cyc = 0;
  int last_cyc = 0;
  int nbytes = 0;
  int drops = 0;
  bit mon_en = 1'b1;
  bit rdy_seen = 1'b0;
  bit irdy_low = 1'b0;

  task automatic chk(input string tag,
                     input logic [79:0] obs,
                     input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (drop) drops++;
    if (out_rdy) rdy_seen = 1'b1;
    if (!in_rdy) irdy_low = 1'b1;
    if (mon_en && out_val) begin
      if (sb.size() == 0) begin
        chk("spurious_val", 80'(out_val), 80'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("byte", {out_sof, out_eof, out_dat},
            {e.s, e.e, e.d});
        if (e.s)
          chk("latency", 80'(cyc - r_cyc), 80'(REQ_DLY));
        else
          chk("contig", 80'(cyc - last_cyc), 80'd1);
        last_cyc = cyc;
        nbytes++;
      end
    end
  end

  task automatic load(input mac_meta_t m,
                      input bit gaps,
                      input bit eof);
    for (int i = 0; i < pl.size(); i++) begin
      if (gaps)
        repeat ($urandom_range(0, 2)) begin
          in_val = 1'b0;
          @(posedge clk); #1;
        end
      in_val  = 1'b1;
      in_dat  = pl[i];
      in_sof  = (i == 0);
      in_eof  = eof && (i == pl.size() - 1);
      in_meta = m;
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    in_sof = 1'b0;
    in_eof = 1'b0;
    if (eof) begin
      @(negedge clk);
      chk("eof_in_rdy", 80'(in_rdy), 80'd0);
      chk("eof_out_rdy", 80'(out_rdy), 80'd1);
    end
  endtask

  task automatic push_exp(input mac_meta_t m,
                          output mac_meta_t em);
    int n;
    int len;
    exp_t e;
    n   = pl.size();
    len = (n < MIN_LEN) ? MIN_LEN : n;
    em           = m;
    em.len       = 16'(len);
    for (int k = 0; k < len; k++) begin
      e.d = (k < n) ? pl[k] : 8'h00;
      e.s = (k == 0);
      e.e = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic req_frame(input mac_meta_t em);
    int g;
    @(posedge clk); #1;
    g = 0;
    while (out_rdy !== 1'b1 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("out_rdy", 80'(out_rdy), 80'd1);
    chk("meta", out_meta, em);
    out_req = 1'b1;
    r_cyc   = cyc + 1;
    @(posedge clk); #1;
    chk("rdy_fall", 80'(out_rdy), 80'd0);
  endtask

  task automatic xmit(input mac_meta_t m);
    mac_meta_t em;
    int g;
    bit ok;
    push_exp(m, em);
    req_frame(em);
    g = 0;
    while (sb.size() != 0 && g < 4000) begin
      @(posedge clk);
      g++;
    end
    chk("drain", 80'(sb.size()), 80'd0);
    #1 out_req = 1'b0;
    ok = 1'b1;
    repeat (IFG + 1) begin
      @(negedge clk);
      if (in_rdy !== 1'b0) ok = 1'b0;
    end
    chk("ifg_hold", 80'(ok), 80'd1);
    @(negedge clk);
    chk("ifg_rdy", 80'(in_rdy), 80'd1);
    chk("meta_clr", out_meta, 80'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mac_meta_t ma;
    mac_meta_t mb;
    mac_meta_t em;
    int d0;
    int nb0;
    int g;

    ma = '{dst_mac: 48'h0011_2233_4455,
           ethertype: 16'h0800, len: 16'hFFFF};
    mb = '{dst_mac: 48'hA1B2_C3D4_E5F6,
           ethertype: 16'h0806, len: 16'h1234};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs",
        80'({in_rdy, out_rdy, out_val, out_sof,
             out_eof, drop, out_dat}), 80'd0);
    chk("rst_meta", out_meta, 80'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 80'(in_rdy), 80'd1);
    @(posedge clk); #1;

    pl.delete();
    for (int i = 0; i < 60; i++) pl.push_back(8'(i));
    load(ma, 1'b0, 1'b1);
    xmit(ma);

    pl.delete();
    for (int i = 0; i < 10; i++)
      pl.push_back(8'(8'hA0 + i));
    load(mb, 1'b0, 1'b1);
    xmit(mb);

    pl.delete();
    for (int i = 0; i < 1500; i++)
      pl.push_back(8'($urandom));
    load(ma, 1'b1, 1'b1);
    xmit(ma);
    chk("no_drop", 80'(drops), 80'd0);

    pl.delete();
    for (int i = 0; i < 2049; i++)
      pl.push_back(8'($urandom));
    d0 = drops;
    rdy_seen = 1'b0;
    irdy_low = 1'b0;
    load(mb, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_drop", 80'(drops - d0), 80'd1);
    chk("ovf_no_rdy", 80'(rdy_seen), 80'd0);
    chk("ovf_in_rdy", 80'(irdy_low), 80'd0);
    pl.delete();
    for (int i = 0; i < 50; i++)
      pl.push_back(8'(8'h30 + i));
    load(ma, 1'b1, 1'b1);
    xmit(ma);

    pl.delete();
    for (int i = 0; i < 5; i++)
      pl.push_back(8'(8'hE0 + i));
    load(ma, 1'b0, 1'b0);
    pl.delete();
    for (int i = 0; i < 20; i++)
      pl.push_back(8'(8'h50 + i));
    load(mb, 1'b0, 1'b1);
    xmit(mb);

    pl.delete();
    for (int i = 0; i < 60; i++)
      pl.push_back(8'(8'hC0 + i));
    load(ma, 1'b0, 1'b1);
    push_exp(ma, em);
    nb0 = nbytes;
    req_frame(em);
    g = 0;
    while (nbytes - nb0 < 20 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    mon_en  = 1'b0;
    rst     = 1'b1;
    out_req = 1'b0;
    sb.delete();
    chk("pre_rst_bytes", 80'(nbytes - nb0), 80'd20);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_outs",
        80'({in_rdy, out_rdy, out_val, out_sof,
             out_eof, drop, out_dat}), 80'd0);
    chk("mid_rst_meta", out_meta, 80'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_rdy", 80'(in_rdy), 80'd1);

    pl.delete();
    for (int i = 0; i < 30; i++)
      pl.push_back(8'(8'h11 * i));
    load(mb, 1'b0, 1'b1);
    xmit(mb);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_vlg_tx_buf.md
# mac_vlg_tx_buf

Store-and-forward single-frame transmit buffer between the upper-layer frame sources (IPv4/ARP mux) and `mac_vlg_tx`. Captures one complete payload plus its MAC header metadata, pads short payloads with zeros to the Ethernet minimum, and presents the frame on the `mac.in_tx` handshake (`rdy`/`req`) with a fixed request-to-data latency. It also enforces an inter-frame gap before accepting the next frame.

## Interface
Parameters:
- `ADDR_W`, 11: log2 of buffer depth in bytes (2048 B, holds a 1500 B payload).
- `MIN_LEN`, 46: minimum payload length; shorter frames are zero-padded.
- `REQ_DLY`, 4: cycles from first sampled `out_req` to payload byte 0 on `out_dat`.
- `IFG`, 12: idle cycles after `out_req` falls before `in_rdy` reasserts.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_dat`  in  8  payload byte from the upper layer.
- `in_val`  in  1  `in_dat` valid; gaps are allowed mid-frame.
- `in_sof`  in  1  qualifies byte 0 and latches `in_meta`.
- `in_eof`  in  1  qualifies the last byte.
- `in_meta`  in  `mac_meta_t`  header (`dst_mac`, `ethertype`); its `len` field is ignored.
- `in_rdy`  out  1  buffer accepts a new frame or its continuation.
- `out_dat`  out  8  payload byte to `mac_vlg_tx`.
- `out_val`  out  1  `out_dat` valid.
- `out_sof`  out  1  high with byte 0.
- `out_eof`  out  1  high with the last byte, `len-1`.
- `out_meta`  out  `mac_meta_t`  latched header; `len` = max(n, `MIN_LEN`).
- `out_rdy`  out  1  complete frame is available.
- `out_req`  in  1  payload request from `mac_vlg_tx`; level, held until its frame is done.
- `drop`  out  1  one-cycle pulse when a frame is discarded on overflow.

## Operation
- The FSM has five states: IDLE, LOAD, READY, SEND, GAP. `in_rdy` is 1 only in IDLE and LOAD.
- IDLE:
  - `in_val & in_sof` stores byte 0 at address 0, latches `in_meta.hdr`, and sets count n=1. Next state is LOAD, or READY if `in_eof` is also high.
  - `in_val` without `in_sof` is ignored.
- LOAD:
  - Each `in_val` stores a byte at address n and increments n.
  - `in_val & in_eof` stores the byte, then moves to READY.
  - `in_val & in_sof` restarts the frame: byte goes to address 0, n=1, `in_meta` is relatched.
  - If n = 2^`ADDR_W` when another byte arrives, the frame is discarded: `drop` pulses 1 cycle, next state is IDLE.
- READY: `out_rdy`=1 and `out_meta` is valid (`len` = max(n,`MIN_LEN`), 16-bit). The first cycle `out_req`=1 moves to SEND.
- SEND:
  - Streams k = 0..len-1. Addresses k ≥ n output 0x00 (padding).
  - After the last byte, next state is GAP.
- GAP: wait for `out_req`=0, then count `IFG` cycles, then go to IDLE.
- `out_meta` holds its value from READY through GAP and is cleared on entering IDLE.

## Timing
- Reset values: `in_rdy`=0, `out_rdy`=0, `out_val`=0, `out_sof`=0, `out_eof`=0, `out_dat`=0, `out_meta`='0, `drop`=0, FSM=IDLE. `in_rdy`=1 from the first cycle after `rst` falls.
- Reset during any state, including mid-SEND, aborts the frame. Outputs take their reset values at that edge; buffer contents are don't-care.
- All outputs are registered.
- Write side:
  - The byte with `in_eof` accepted at edge E gives `in_rdy`=0 and `out_rdy`=1 from E+1.
  - Frame turnaround is 1 cycle from last write to `out_rdy`.
- Read side:
  - `out_req` first sampled high at edge R gives `out_rdy`=0 from R+1.
  - Byte k appears with `out_val`=1 on the cycle after edge R+`REQ_DLY`+k.
  - `out_val` stays high for exactly len consecutive cycles, with no bubbles.
- `out_sof` and `out_eof` are single-cycle and coincide with bytes 0 and len-1. Both are high in the same cycle only if len=1, which cannot occur while `MIN_LEN` ≥ 2.
- `in_rdy` reasserts `IFG` cycles after the first cycle `out_req`=0 in GAP.
- RAM is inferred simple dual-port with 1-cycle synchronous read. `REQ_DLY` ≥ 2.

## Test plan
- **60-byte payload 0x00..0x3B, contiguous `in_val`:**
  - `out_meta.len`=60.
  - After `out_req`, 60 bytes 0x00..0x3B from R+`REQ_DLY`+1.
  - `out_sof` on 0x00, `out_eof` on 0x3B.
- **10-byte payload 0xA0..0xA9:**
  - `len`=46; bytes 0xA0..0xA9 followed by 36×0x00.
  - `out_eof` on byte 45.
- **1500-byte payload with random `in_val` gaps:** output identical and contiguous; `in_rdy`=0 from eof+1 until `IFG` cycles after `out_req` falls.
- **Overflow, 2049 bytes with no `in_eof`:**
  - `drop` pulses once on byte 2049.
  - `out_rdy` never asserts; `in_rdy` stays 1.
  - Next valid frame transmits correctly.
- **Restart:** second `in_sof` after 5 bytes of a frame; only the second frame is emitted, with the second `in_meta`.
- **Reset mid-SEND, at byte 20:**
  - All outputs 0 at the next edge; `in_rdy`=1 the cycle after `rst` falls.
  - A new frame is sent normally.
